// File: rtl/wb_port_arbiter_if.sv
// Bundle of the ALU/load writeback requests, the decode read indices and the
// arbitrated bank/PC write port.
interface wb_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          ALU_Valid;
    logic [AW-1:0] ALU_A3;
    logic [DW-1:0] ALU_WD;
    logic          MEM_Valid;
    logic [AW-1:0] MEM_A3;
    logic [DW-1:0] MEM_WD;
    logic          MEM_Ready;
    logic [AW-1:0] RA1;
    logic [AW-1:0] RA2;
    logic          Pend1;
    logic          Pend2;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          PC_WE;
    logic [DW-1:0] PC_WD;

    modport master (
        output ALU_Valid, ALU_A3, ALU_WD, MEM_Valid, MEM_A3, MEM_WD, RA1, RA2,
        input  MEM_Ready, Pend1, Pend2, WE3, A3, WD3, PC_WE, PC_WD
    );

    modport slave (
        input  ALU_Valid, ALU_A3, ALU_WD, MEM_Valid, MEM_A3, MEM_WD, RA1, RA2,
        output MEM_Ready, Pend1, Pend2, WE3, A3, WD3, PC_WE, PC_WD
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register bank write port between a never-stalled ALU source
// and a FIFO-buffered load source; index 15 is redirected to the PC port.
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    wb_port_arbiter_if.slave bus
);
    localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW     = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PC_IDX = '1;

    logic [AW-1:0]    fifo_a [DEPTH];
    logic [DW-1:0]    fifo_d [DEPTH];
    logic [DEPTH-1:0] fifo_v;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic          accept;
    logic          push;
    logic          pop;
    logic          issue;
    logic [AW-1:0] issue_a;
    logic [DW-1:0] issue_d;
    logic          pend1;
    logic          pend2;

    assign bus.MEM_Ready = (count < CW'(DEPTH));
    assign accept        = bus.MEM_Valid && bus.MEM_Ready;
    assign bus.Pend1     = pend1;
    assign bus.Pend2     = pend2;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        issue   = 1'b0;
        issue_a = bus.ALU_A3;
        issue_d = bus.ALU_WD;
        push    = 1'b0;
        pop     = 1'b0;
        if (bus.ALU_Valid) begin
            issue = 1'b1;
            push  = accept;
        end else if (count != '0) begin
            // A cancelled head still spends its cycle, it just writes nothing.
            pop     = 1'b1;
            issue   = fifo_v[rd_ptr];
            issue_a = fifo_a[rd_ptr];
            issue_d = fifo_d[rd_ptr];
            push    = accept;
        end else if (accept) begin
            issue   = 1'b1;
            issue_a = bus.MEM_A3;
            issue_d = bus.MEM_WD;
        end
    end

    always_comb begin
        pend1 = bus.WE3 && (bus.A3 == bus.RA1);
        pend2 = bus.WE3 && (bus.A3 == bus.RA2);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_v[i] && (fifo_a[i] == bus.RA1)) pend1 = 1'b1;
            if (fifo_v[i] && (fifo_a[i] == bus.RA2)) pend2 = 1'b1;
        end
        if (bus.RA1 == PC_IDX) pend1 = 1'b0;
        if (bus.RA2 == PC_IDX) pend2 = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fifo_v    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            bus.WE3   <= 1'b0;
            bus.A3    <= '0;
            bus.WD3   <= '0;
            bus.PC_WE <= 1'b0;
            bus.PC_WD <= '0;
        end else begin
            // An ALU write supersedes any older buffered load to the same index.
            if (bus.ALU_Valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifo_a[i] == bus.ALU_A3) fifo_v[i] <= 1'b0;
                end
            end
            if (pop) begin
                fifo_v[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (push) begin
                fifo_v[wr_ptr] <= !(bus.ALU_Valid && (bus.MEM_A3 == bus.ALU_A3));
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            if (issue && (issue_a == PC_IDX)) begin
                bus.PC_WE <= 1'b1;
                bus.PC_WD <= issue_d;
                bus.WE3   <= 1'b0;
            end else if (issue) begin
                bus.WE3   <= 1'b1;
                bus.A3    <= issue_a;
                bus.WD3   <= issue_d;
                bus.PC_WE <= 1'b0;
            end else begin
                bus.WE3   <= 1'b0;
                bus.PC_WE <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is not reset; fifo_v alone says which slots hold live data.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_a[wr_ptr] <= bus.MEM_A3;
            fifo_d[wr_ptr] <= bus.MEM_WD;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register bank's single write port (WE3/A3/WD3) between two writeback sources.
- The ALU writeback source is fixed-priority and is never stalled. The memory-load writeback source uses a valid/ready handshake and is buffered in a 2-entry FIFO.
- Writes to index 15 are steered to a separate PC write port, because R15 is not held in the bank.
- Also reports pending (in-flight) writes to the two read indices so decode can stall.

Parameters:
DEPTH, 2, MEM FIFO entries (power of 2; only 2 is required and verified)
DW, 32, data width
AW, 4, register index width

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
ALU_Valid  in  1  ALU writeback request this cycle (always accepted)
ALU_A3  in  AW  ALU destination index
ALU_WD  in  DW  ALU result
MEM_Valid  in  1  load writeback request
MEM_A3  in  AW  load destination index
MEM_WD  in  DW  load data
MEM_Ready  out  1  arbiter can accept a load request this cycle
RA1  in  AW  decode read index 1
RA2  in  AW  decode read index 2
Pend1  out  1  write to RA1 still in flight
Pend2  out  1  write to RA2 still in flight
WE3  out  1  bank write enable (registered)
A3  out  AW  bank write index (registered)
WD3  out  DW  bank write data (registered)
PC_WE  out  1  PC write enable (registered)
PC_WD  out  DW  PC write data (registered)

Behaviour:
- Reset, synchronous and active-high:
  - WE3, A3, WD3, PC_WE and PC_WD all clear to 0.
  - FIFO count clears to 0 and all entries are invalid.
  - MEM_Ready reads 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all buffered entries; no write issues in the following cycle.
- Load handshake:
  - A load is accepted when MEM_Valid && MEM_Ready.
  - MEM_Ready = (count < DEPTH), combinational from state only. It never depends on MEM_Valid or ALU_Valid.
- Source selection (per cycle, priority order):
  1. ALU_Valid: issue the ALU request.
  2. Else FIFO non-empty: pop the head and issue it.
  3. Else an accepted load: bypass the FIFO and issue it directly.
  4. Else: issue nothing.
- An accepted load that is not issued is pushed at the tail. Push and pop may occur in the same cycle; count is then unchanged.
- Issue latency is 1 cycle: request in cycle N, outputs valid in cycle N+1.
  - Issued index != 15: WE3=1, A3/WD3 from the request, PC_WE=0.
  - Issued index == 15: PC_WE=1, PC_WD = data, WE3=0, A3/WD3 hold their previous values.
  - Otherwise WE3=0 and PC_WE=0.
- Write-after-write cancellation:
  - When an ALU request issues with index X, every valid FIFO entry with index X is marked invalid. The entry still occupies its slot.
  - A load accepted in the same cycle with index X is pushed already invalid. The load is treated as older than the ALU write.
  - Popping an invalid entry consumes the cycle and issues nothing (WE3=0, PC_WE=0).
- Pend1 / Pend2 (combinational):
  - Pend1 = 1 if RA1 != 15 and RA1 matches either (a) any valid FIFO entry, or (b) A3 while WE3=1.
  - Pend2 is the same using RA2.
  - A request still on the input ports in the current cycle is not reported.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Count is DEPTH-bit-safe: it never exceeds DEPTH and never underflows.
- Load requests are issued in acceptance order. ALU requests may overtake buffered loads.

Test Plan:
- Reset, then MEM_Valid=1, A3=3, WD=0xAAAA0001, no ALU request → next cycle WE3=1, A3=3, WD3=0xAAAA0001 (bypass); MEM_Ready stays 1.
- ALU_Valid=1 for 3 consecutive cycles (A3=1,2,4) while MEM_Valid=1 with A3=5,6,7:
  - MEM_Ready goes 1,1,0 and only loads 5 and 6 are accepted.
  - After the ALU stops, WE3 shows 5, then 6, then load 7 (re-presented and accepted).
- Load to index 8 buffered, then ALU writes index 8 with 0x11 → bank sees only WD3=0x11 for index 8; the popped slot gives WE3=0; count returns to 0.
- ALU write to index 15 with 0x0000_0100 → PC_WE=1, PC_WD=0x100, WE3=0; Pend1=0 for RA1=15.
- Two loads buffered (indices 9 and 10), RA1=10, RA2=11 → Pend1=1, Pend2=0. After both issue: Pend1=0. FIFO wrap check: 6 back-to-back loads, each with one ALU cycle interleaved → all 6 issue in order.
- Reset asserted with 2 entries buffered → next cycle WE3=0, PC_WE=0, MEM_Ready=1; no buffered entry ever issues.
